// File: rtl/alu_mdu.sv
// alu_mdu: handshaked RV OP/OP-IMM ALU with iterative M-extension multiply/divide.
// Define ALU_MDU_EARLY_OUT_EN to finish zero-operand multiplies and div-by-zero/overflow in one cycle.
module alu_mdu #(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            op,
    input  logic            op_imm,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] t,
    output logic            illegal,
    output logic            busy
);
    localparam int S = XLEN / UNROLL;
    localparam int CW = $clog2(S) + 1;
    localparam int SW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(S - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [1:0]      f3_q;
    logic [2*XLEN:0] acc_q, mul_d, div_d;
    logic [XLEN-1:0] mcand_q, t_q;
    logic            neg_q, rneg_q, dz_q, ov_q, ill_q;

    logic            is_m, legal_op, legal_imm, illegal_d, a_neg, b_neg, accept, early;
    logic [XLEN-1:0] mag_a, mag_b, base_res, early_res, res_d, mul_res, div_res, quo, rem;
    logic [2*XLEN-1:0] prod;
    logic [SW-1:0]   shamt;

    assign is_m      = op && funct7 == 7'b0000001;
    assign legal_op  = op && (funct7 == 7'b0 || (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)));
    assign legal_imm = !op && op_imm && funct7 != 7'b0000001 &&
                       (funct3 != 3'b101 || funct7 == 7'b0 || funct7 == 7'b0100000);
    assign illegal_d = !(is_m || legal_op || legal_imm);
    assign shamt     = b[SW-1:0];
    assign accept    = in_valid && in_ready;

    // Signedness per funct3: MUL/MULH/MULHSU take a signed, MUL/MULH take b signed; DIV/REM both signed.
    assign a_neg = a[XLEN-1] && (funct3[2] ? !funct3[0] : funct3[1:0] != 2'b11);
    assign b_neg = b[XLEN-1] && (funct3[2] ? !funct3[0] : !funct3[1]);
    assign mag_a = a_neg ? -a : a;
    assign mag_b = b_neg ? -b : b;

    always_comb begin
        base_res = '0;
        case (funct3)
            3'b000:  base_res = (op && funct7[5]) ? a - b : a + b;
            3'b001:  base_res = a << shamt;
            3'b010:  base_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            3'b011:  base_res = {{(XLEN-1){1'b0}}, a < b};
            3'b100:  base_res = a ^ b;
            3'b101:  base_res = funct7[5] ? $unsigned($signed(a) >>> shamt) : a >> shamt;
            3'b110:  base_res = a | b;
            default: base_res = a & b;
        endcase
    end

`ifdef ALU_MDU_EARLY_OUT_EN
    logic ovf;
    assign ovf       = !funct3[0] && a == {1'b1, {(XLEN-1){1'b0}}} && &b;
    assign early     = is_m && (funct3[2] ? (b == '0 || ovf) : (a == '0 || b == '0));
    assign early_res = !funct3[2] ? '0 : b == '0 ? (funct3[1] ? a : '1) : (funct3[1] ? '0 : a);
`else
    assign early     = 1'b0;
    assign early_res = '0;
`endif

    assign res_d = illegal_d ? '0 : is_m ? early_res : base_res;

    // acc_q holds {carry, hi, multiplier} for MUL and {remainder, quotient} for DIV.
    always_comb begin
        mul_d = acc_q;
        div_d = acc_q;
        for (int i = 0; i < UNROLL; i++) begin
            if (mul_d[0]) mul_d[2*XLEN:XLEN] = mul_d[2*XLEN:XLEN] + {1'b0, mcand_q};
            mul_d = mul_d >> 1;
            div_d = div_d << 1;
            if (div_d[2*XLEN:XLEN] >= {1'b0, mcand_q}) begin
                div_d[2*XLEN:XLEN] = div_d[2*XLEN:XLEN] - {1'b0, mcand_q};
                div_d[0] = 1'b1;
            end
        end
    end

    assign prod    = neg_q ? -mul_d[2*XLEN-1:0] : mul_d[2*XLEN-1:0];
    assign mul_res = f3_q == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    assign quo     = dz_q ? '1 : neg_q ? -div_d[XLEN-1:0] : div_d[XLEN-1:0];
    assign rem     = rneg_q ? -div_d[2*XLEN-1:XLEN] : div_d[2*XLEN-1:XLEN];
    assign div_res = f3_q[1] ? rem : quo;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            t_q     <= '0;
            ill_q   <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            if (ov_q && out_ready) ov_q <= 1'b0;
            if (state_q == IDLE) begin
                if (accept && is_m && !early) begin
                    state_q <= funct3[2] ? DIV : MUL;
                    cnt_q   <= '0;
                    f3_q    <= funct3[1:0];
                    acc_q   <= {{(XLEN+1){1'b0}}, funct3[2] ? mag_a : mag_b};
                    mcand_q <= funct3[2] ? mag_b : mag_a;
                    neg_q   <= a_neg ^ b_neg;
                    rneg_q  <= a_neg;
                    dz_q    <= b == '0;
                end else if (accept) begin
                    t_q   <= res_d;
                    ill_q <= illegal_d;
                    ov_q  <= 1'b1;
                end
            end else begin
                acc_q <= state_q == MUL ? mul_d : div_d;
                cnt_q <= cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_q <= IDLE;
                    t_q     <= state_q == MUL ? mul_res : div_res;
                    ill_q   <= 1'b0;
                    ov_q    <= 1'b1;
                end
            end
        end
    end

    assign in_ready  = state_q == IDLE && (!ov_q || out_ready);
    assign out_valid = ov_q;
    assign t         = t_q;
    assign illegal   = ill_q;
    assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: directed vectors for alu_mdu checked against an arithmetic reference model.
module tb_alu_mdu;
    logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, op = 1'b0, op_imm = 1'b0, out_ready = 1'b1;
    logic        in_ready, out_valid, illegal, busy;
    logic [2:0]  funct3 = '0;
    logic [6:0]  funct7 = '0;
    logic [31:0] a = '0, b = '0, t;
    int          checks = 0, passes = 0, cyc = 0;
    bit          seen = 1'b0;

    typedef struct {
        logic [31:0] t;
        logic        ill;
        int          lat;
        int          acc;
    } exp_t;
    exp_t exp_q[$];

    alu_mdu #(.XLEN(32), .UNROLL(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .op_imm(op_imm),
        .funct3(funct3), .funct7(funct7), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .t(t), .illegal(illegal), .busy(busy)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Reference: {illegal, t} from plain 64-bit arithmetic.
    function automatic logic [32:0] model(input logic o, input logic oi, input logic [2:0] f3,
                                          input logic [6:0] f7, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sx, sy;
        logic [63:0] ux, uy, p;
        logic [31:0] r;
        logic legal;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        ux = {32'b0, x};
        uy = {32'b0, y};
        legal = (o && (f7 == 7'h00 || f7 == 7'h01 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)))) ||
                (!o && oi && f7 != 7'h01 && (f3 != 3'd5 || f7 == 7'h00 || f7 == 7'h20));
        if (!legal) return {1'b1, 32'b0};
        p = '0;
        r = '0;
        if (o && f7 == 7'h01) begin
            case (f3)
                3'd0: begin p = ux * uy; r = p[31:0]; end
                3'd1: begin p = sx * sy; r = p[63:32]; end
                3'd2: begin p = sx * uy; r = p[63:32]; end
                3'd3: begin p = ux * uy; r = p[63:32]; end
                3'd4: begin
                    if (y == 0) r = '1;
                    else if (x == 32'h80000000 && y == 32'hffffffff) r = x;
                    else r = $signed(x) / $signed(y);
                end
                3'd5: r = (y == 0) ? 32'hffffffff : x / y;
                3'd6: begin
                    if (y == 0) r = x;
                    else if (x == 32'h80000000 && y == 32'hffffffff) r = 0;
                    else r = $signed(x) % $signed(y);
                end
                default: r = (y == 0) ? x : x % y;
            endcase
        end else begin
            case (f3)
                3'd0: r = (o && f7 == 7'h20) ? x - y : x + y;
                3'd1: r = x << y[4:0];
                3'd2: r = {31'b0, sx < sy};
                3'd3: r = {31'b0, x < y};
                3'd4: r = x ^ y;
                3'd5: begin p = (f7 == 7'h20) ? ux | (sx & 64'hffffffff_00000000) : ux; p = p >> y[4:0]; r = p[31:0]; end
                3'd6: r = x | y;
                default: r = x & y;
            endcase
        end
        return {1'b0, r};
    endfunction

    function automatic int lat_of(input logic o, input logic [2:0] f3, input logic [6:0] f7,
                                  input logic [31:0] x, input logic [31:0] y);
        if (!(o && f7 == 7'h01)) return 1;
`ifdef ALU_MDU_EARLY_OUT_EN
        if (f3[2] && (y == 0 || (!f3[0] && x == 32'h80000000 && y == 32'hffffffff))) return 1;
        if (!f3[2] && (x == 0 || y == 0)) return 1;
`else
        if (f3 == 3'd7 && x == 32'h1 && y == 32'h1) return 33;
`endif
        return 33;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            seen = 1'b0;
        end else if (out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL spurious_valid: got out_valid=1 t=%h, expected out_valid=0", t);
            end else begin
                chk("t", t, exp_q[0].t);
                chk("illegal", {31'b0, illegal}, {31'b0, exp_q[0].ill});
                if (!seen) begin
                    chk("latency", 32'(cyc - exp_q[0].acc), 32'(exp_q[0].lat));
                    seen = 1'b1;
                end
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    // Call just after a rising edge; returns just after the edge that accepts the op.
    task automatic issue(input logic o, input logic oi, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] x, input logic [31:0] y);
        int n;
        logic [32:0] m;
        op = o; op_imm = oi; funct3 = f3; funct7 = f7; a = x; b = y; in_valid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!in_ready && n < 200);
        if (!in_ready) begin
            checks++;
            $display("FAIL accept_timeout: got in_ready=0, expected 1");
        end else begin
            m = model(o, oi, f3, f7, x, y);
            exp_q.push_back('{m[31:0], m[32], lat_of(o, f3, f7, x, y), cyc});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        do begin @(posedge clk); n++; end while (exp_q.size() != 0 && n < 100);
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL drain_timeout: got %0d pending results, expected 0", exp_q.size());
        end
        #1;
    endtask

    initial begin
        logic [32:0] m;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_t", t, 32'd0);
        chk("rst_illegal", {31'b0, illegal}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;

        m = model(1, 0, 3'd0, 7'h00, 7, 5);                     chk("pin_add", m[31:0], 32'd12);
        m = model(1, 0, 3'd5, 7'h20, 32'h80000000, 32'h24);     chk("pin_sra", m[31:0], 32'hf8000000);
        m = model(1, 0, 3'd3, 7'h01, '1, '1);                   chk("pin_mulhu", m[31:0], 32'hfffffffe);
        m = model(1, 0, 3'd2, 7'h01, '1, '1);                   chk("pin_mulhsu", m[31:0], 32'hffffffff);
        m = model(1, 0, 3'd4, 7'h01, 32'hfffffff9, 2);          chk("pin_div", m[31:0], 32'hfffffffd);
        m = model(1, 0, 3'd6, 7'h01, 32'hfffffff9, 2);          chk("pin_rem", m[31:0], 32'hffffffff);
        m = model(0, 0, 3'd0, 7'h00, 1, 1);                     chk("pin_illegal", {31'b0, m[32]}, 32'd1);

        // Base ops, back to back.
        issue(1, 0, 3'd0, 7'h00, 7, 5);
        issue(1, 0, 3'd0, 7'h20, 7, 5);
        issue(0, 1, 3'd0, 7'h20, 7, 5);
        issue(1, 0, 3'd5, 7'h20, 32'h80000000, 32'h24);
        issue(1, 0, 3'd1, 7'h00, 1, 32'h21);
        issue(1, 0, 3'd5, 7'h00, 32'h80000000, 32'h4);
        issue(0, 1, 3'd5, 7'h20, 32'h80000010, 32'h3);
        issue(1, 0, 3'd2, 7'h00, 32'hffffffff, 1);
        issue(1, 0, 3'd3, 7'h00, 32'hffffffff, 1);
        issue(1, 0, 3'd4, 7'h00, 32'hf0f0f0f0, 32'h0ff00ff0);
        issue(0, 1, 3'd6, 7'h00, 32'h12340000, 32'h00005678);
        issue(1, 0, 3'd7, 7'h00, 32'hdeadbeef, 32'h0000ffff);
        issue(0, 0, 3'd0, 7'h00, 1, 1);
        issue(1, 0, 3'd0, 7'h10, 1, 1);
        issue(0, 1, 3'd5, 7'h01, 1, 1);
        wait_done();

        // MULH with busy/in_ready profile over the iteration window.
        issue(1, 0, 3'd1, 7'h01, '1, '1);
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            chk("mul_busy", {31'b0, busy}, 32'd1);
            chk("mul_in_ready", {31'b0, in_ready}, 32'd0);
        end
        @(negedge clk);
        chk("mul_busy_end", {31'b0, busy}, 32'd0);
        chk("mul_out_valid", {31'b0, out_valid}, 32'd1);
        wait_done();

        issue(1, 0, 3'd3, 7'h01, '1, '1);
        issue(1, 0, 3'd0, 7'h01, '1, '1);
        issue(1, 0, 3'd2, 7'h01, '1, '1);
        issue(1, 0, 3'd0, 7'h01, 32'd12345, 32'hfffffffd);
        issue(1, 0, 3'd1, 7'h01, 32'h0, 32'h7);
        issue(1, 0, 3'd4, 7'h01, 32'hfffffff9, 2);
        issue(1, 0, 3'd6, 7'h01, 32'hfffffff9, 2);
        issue(1, 0, 3'd4, 7'h01, 32'h80000000, 32'hffffffff);
        issue(1, 0, 3'd6, 7'h01, 32'h80000000, 32'hffffffff);
        issue(1, 0, 3'd5, 7'h01, 9, 0);
        issue(1, 0, 3'd7, 7'h01, 9, 0);
        issue(1, 0, 3'd4, 7'h01, 32'hfffffff9, 0);
        issue(1, 0, 3'd6, 7'h01, 32'hfffffff9, 0);
        issue(1, 0, 3'd5, 7'h01, 100, 7);
        issue(1, 0, 3'd7, 7'h01, 100, 7);
        wait_done();

        // Backpressure: result held, then retire and accept in the same cycle.
        out_ready = 1'b0;
        issue(1, 0, 3'd0, 7'h00, 7, 5);
        repeat (5) begin
            @(negedge clk);
            chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        issue(1, 0, 3'd4, 7'h00, 12, 10);
        wait_done();

        // Reset during the 10th divide iteration.
        issue(1, 0, 3'd4, 7'h01, 100, 7);
        repeat (9) @(posedge clk);
        #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        issue(1, 0, 3'd0, 7'h00, 1, 1);
        wait_done();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
